// File: rtl/fft_frame_fifo_if.sv
// fft_frame_fifo_if
//   Bundles the sample handshakes on both sides of the FFT output FIFO.
//   Upstream side : in_valid / in_ready / in_re / in_img
//   Downstream    : out_valid / out_ready / out_re / out_img / out_index /
//                   out_last / frame_done, plus the count occupancy status.
//   modport slave  : the FIFO itself (consumes in_*, produces out_*)
//   modport master : the environment around the FIFO (producer + consumer)
// Parameters
//   AW  FIFO address width (count is AW+1 bits)
//   IW  width of out_index
interface fft_frame_fifo_if #(
  parameter int AW = 4,
  parameter int IW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_re;
  logic [31:0]   in_img;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_re;
  logic [31:0]   out_img;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          frame_done;
  logic [AW:0]   count;

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, out_valid, out_re, out_img, out_index, out_last,
           frame_done, count
  );

  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, out_valid, out_re, out_img, out_index, out_last,
           frame_done, count
  );
endinterface

// File: rtl/fft_frame_fifo.sv
// fft_frame_fifo
//   Output buffer behind the radix-5 FFT 1/N scaling stage. Stores complex
//   single-precision samples (re/img) and presents them first-word-fall-through
//   with a per-frame sample index, a last-of-frame flag and a frame-done pulse.
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset (control state only; memory is kept)
//   bus  fft_frame_fifo_if.slave:
//          in_valid/in_ready/in_re/in_img      upstream write handshake
//          out_valid/out_ready/out_re/out_img  downstream FWFT read handshake
//          out_index   head sample position within its frame
//          out_last    head is the last sample of a frame
//          frame_done  one-cycle pulse after the last sample is taken
//          count       occupancy 0..DEPTH
// Configuration
//   DENORM_FLUSH_EN  when defined, a component with a zero exponent field is
//                    stored as a signed zero; otherwise data is stored bit-exact.
module fft_frame_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int FRAME_LEN = 125,
  parameter int IW        = 7
) (
  input logic              clk,
  input logic              rst,
  fft_frame_fifo_if.slave  bus
);

  localparam int              DATA_W   = 32;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

  // Zero/denormal components become a signed zero so the consumer never
  // sees subnormals produced by the 1/N scaling.
  function automatic logic [DATA_W-1:0] flush_denorm(input logic [DATA_W-1:0] x);
`ifdef DENORM_FLUSH_EN
    if (x[30:23] == 8'd0) begin
      flush_denorm = {x[31], 31'd0};
    end else begin
      flush_denorm = x;
    end
`else
    flush_denorm = x;
`endif
  endfunction

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         count_q;
  logic [IW-1:0]       index_q;
  logic                frame_done_q;

  logic full;
  logic empty;
  logic wr;
  logic rd;
  logic idx_at_last;
  logic [2*DATA_W-1:0] head;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign wr          = bus.in_valid && !full;
  assign rd          = bus.out_ready && !empty;
  assign idx_at_last = (index_q == LAST_IDX);

  // Write stage: flushed sample lands in memory at the write pointer.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[wptr] <= {flush_denorm(bus.in_re), flush_denorm(bus.in_img)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count_q      <= '0;
      index_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd) begin
        rptr    <= rptr + PTR_ONE;
        index_q <= idx_at_last ? '0 : index_q + IDX_ONE;
      end
      case ({wr, rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      frame_done_q <= rd && idx_at_last;
    end
  end

  // Read stage: head word is presented combinationally from the read pointer.
  assign head           = mem[rptr];
  assign bus.out_re     = head[2*DATA_W-1:DATA_W];
  assign bus.out_img    = head[DATA_W-1:0];
  assign bus.out_valid  = !empty;
  assign bus.in_ready   = !full;
  assign bus.out_index  = index_q;
  assign bus.out_last   = !empty && idx_at_last;
  assign bus.frame_done = frame_done_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_fft_frame_fifo.sv
module tb_fft_frame_fifo;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int FRAME_LEN = 125;
  localparam int IW        = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_fifo_if #(.AW(AW), .IW(IW)) bus ();

  fft_frame_fifo #(
    .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FRAME_LEN), .IW(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus a frame position counter.
  logic [63:0] q[$];
  int          m_idx     = 0;
  bit          m_fd      = 1'b0;
  bit          started   = 1'b0;
  int          m_wr_cnt  = 0;
  int          m_rd_cnt  = 0;
  int          last_hs   = 0;
  int          fd_cnt    = 0;

  function automatic logic [31:0] m_store(input logic [31:0] x);
`ifdef DENORM_FLUSH_EN
    if (x[30:23] == 8'd0) return x & 32'h8000_0000;
`endif
    return x;
  endfunction

  always @(posedge clk) begin
    bit wr, rd;
    if (rst) begin
      q.delete();
      m_idx   = 0;
      m_fd    = 1'b0;
      started = 1'b1;
    end else begin
      wr   = bus.in_valid && (q.size() < DEPTH);
      rd   = bus.out_ready && (q.size() > 0);
      m_fd = rd && (m_idx == FRAME_LEN - 1);
      if (rd) begin
        void'(q.pop_front());
        m_idx = (m_idx + 1) % FRAME_LEN;
        m_rd_cnt++;
      end
      if (wr) begin
        q.push_back({m_store(bus.in_re), m_store(bus.in_img)});
        m_wr_cnt++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_valid;
    if (started) begin
      exp_valid = (q.size() > 0);
      chk("out_valid",  64'(bus.out_valid),  64'(exp_valid));
      chk("in_ready",   64'(bus.in_ready),   64'(q.size() < DEPTH));
      chk("count",      64'(bus.count),      64'(q.size()));
      chk("out_index",  64'(bus.out_index),  64'(m_idx));
      chk("out_last",   64'(bus.out_last),   64'(exp_valid && (m_idx == FRAME_LEN - 1)));
      chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
      if (exp_valid) begin
        chk("out_data", {bus.out_re, bus.out_img}, q[0]);
      end
      if (bus.out_last && bus.out_ready) last_hs++;
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(3) == 0) w[30:23] = 8'd0;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_re     = '0;
    bus.in_img    = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("init_count",    64'(bus.count),     64'd0);
    chk("init_in_ready", 64'(bus.in_ready),  64'd1);
    chk("init_valid",    64'(bus.out_valid), 64'd0);

    // Single write into an empty FIFO, consumer stalled.
    bus.in_valid = 1'b1;
    bus.in_re    = 32'h3F80_0000;
    bus.in_img   = 32'hC000_0000;
    tick();
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_img   = '0;
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_re",    64'(bus.out_re),    64'h3F80_0000);
    chk("t2_img",   64'(bus.out_img),   64'hC000_0000);
    repeat (3) tick();
    chk("t2_hold_re",  64'(bus.out_re),  64'h3F80_0000);
    chk("t2_hold_img", 64'(bus.out_img), 64'hC000_0000);

    // Fill to full, the 17th write must be refused.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = rnd_word();
      bus.in_img   = rnd_word();
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t3_full_count", 64'(bus.count),    64'd16);
    chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t3_after_rd_count", 64'(bus.count),    64'd15);
    chk("t3_after_rd_ready", 64'(bus.in_ready), 64'd1);

    // Steady state at occupancy 8 with a write and a read every cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = rnd_word();
      bus.in_img   = rnd_word();
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_re  = rnd_word();
      bus.in_img = rnd_word();
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4_count", 64'(bus.count), 64'd8);

    // Reset held two cycles in the middle of a random burst.
    for (int i = 0; i < 40; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = ($urandom_range(2) == 0);
      bus.in_re     = rnd_word();
      bus.in_img    = rnd_word();
      tick();
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t1_count",      64'(bus.count),      64'd0);
    chk("t1_valid",      64'(bus.out_valid),  64'd0);
    chk("t1_index",      64'(bus.out_index),  64'd0);
    chk("t1_frame_done", 64'(bus.frame_done), 64'd0);
    chk("t1_in_ready",   64'(bus.in_ready),   64'd1);

    // Two full frames streamed with random gaps on both sides.
    do_reset();
    m_wr_cnt = 0;
    m_rd_cnt = 0;
    last_hs  = 0;
    fd_cnt   = 0;
    cyc      = 0;
    while (m_rd_cnt < 2 * FRAME_LEN && cyc < 6000) begin
      bus.in_valid  = (m_wr_cnt < 2 * FRAME_LEN) && ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.in_re     = rnd_word();
      bus.in_img    = rnd_word();
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t5_all_read", 64'(m_rd_cnt), 64'(2 * FRAME_LEN));
    tick();
    tick();
    chk("t5_last_count",       64'(last_hs),       64'd2);
    chk("t5_frame_done_count", 64'(fd_cnt),        64'd2);
    chk("t5_index_wrapped",    64'(bus.out_index), 64'd0);

    // Denormal / zero-exponent components.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_re    = 32'h8000_0001;
    bus.in_img   = 32'h0040_0000;
    tick();
    bus.in_valid = 1'b0;
`ifdef DENORM_FLUSH_EN
    chk("t6_re",  64'(bus.out_re),  64'h8000_0000);
    chk("t6_img", 64'(bus.out_img), 64'h0000_0000);
`else
    chk("t6_re",  64'(bus.out_re),  64'h8000_0001);
    chk("t6_img", 64'(bus.out_img), 64'h0040_0000);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(63) == 0);
      bus.in_valid  = ($urandom_range(1) == 0);
      bus.out_ready = ($urandom_range(2) != 0);
      bus.in_re     = rnd_word();
      bus.in_img    = rnd_word();
      tick();
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
